// File: rtl/data_mem_responder.sv
// Load/store responder backed by a word-organised RAM with byte/half/word lanes.
// Optional macro DMEM_MISALIGN_CHECK_EN turns misaligned halves/words into faults.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid_in,
  output logic              req_ready_out,
  input  logic              req_we_in,
  input  logic [ADDR_W-1:0] req_addr_in,
  input  logic [31:0]       req_wdata_in,
  input  logic [1:0]        req_size_in,
  input  logic              req_unsigned_in,
  output logic              resp_valid_out,
  input  logic              resp_ready_in,
  output logic [31:0]       resp_rdata_out,
  output logic              resp_err_out
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] wordIdx;
  logic             outOfRange;
  logic             misalign;
  logic             reqErr;
  logic [3:0]       byteEn;
  logic [31:0]      laneData;
  logic             accept;
  logic             memWrite;

  logic        we_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [1:0]  lane_q;
  logic        err_q;
  logic [31:0] rdWord_q;
  logic [31:0] respData_q;
  logic        respErr_q;

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;

  // Decode the live request; only consumed at the accept edge.
  always_comb begin
    wordIdx    = req_addr_in[IDX_W+1:2];
    outOfRange = ({1'b0, req_addr_in} >= LIMIT);
`ifdef DMEM_MISALIGN_CHECK_EN
    misalign   = ((req_size_in == 2'b01) && req_addr_in[0]) ||
                 ((req_size_in == 2'b10) && (req_addr_in[1:0] != 2'b00));
`else
    misalign   = 1'b0;
`endif
    reqErr     = outOfRange || (req_size_in == 2'b11) || misalign;
    case (req_size_in)
      2'b00: begin
        byteEn   = 4'b0001 << req_addr_in[1:0];
        laneData = {4{req_wdata_in[7:0]}};
      end
      2'b01: begin
        byteEn   = req_addr_in[1] ? 4'b1100 : 4'b0011;
        laneData = {2{req_wdata_in[15:0]}};
      end
      default: begin
        byteEn   = 4'b1111;
        laneData = req_wdata_in;
      end
    endcase
  end

  assign accept   = req_valid_in && (state_q == IDLE);
  // Gating with rst_in keeps a store that coincides with reset out of the RAM.
  assign memWrite = accept && req_we_in && !reqErr && rst_in;

  always_ff @(posedge clk_in) begin
    if (memWrite) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= laneData[8*b +: 8];
      end
    end
    if (accept) rdWord_q <= mem[wordIdx];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      lane_q     <= 2'b00;
      err_q      <= 1'b0;
      respData_q <= 32'h0;
      respErr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q       <= req_we_in;
        size_q     <= req_size_in;
        unsigned_q <= req_unsigned_in;
        lane_q     <= req_addr_in[1:0];
        err_q      <= reqErr;
      end
      if (state_q == ACCESS) begin
        respData_q <= loadData;
        respErr_q  <= err_q;
      end
    end
  end

  always_comb begin
    loadByte = rdWord_q[{lane_q, 3'b000} +: 8];
    loadHalf = rdWord_q[{lane_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   loadData = unsigned_q ? {24'h0, loadByte} : {{24{loadByte[7]}}, loadByte};
      2'b01:   loadData = unsigned_q ? {16'h0, loadHalf} : {{16{loadHalf[15]}}, loadHalf};
      default: loadData = rdWord_q;
    endcase
    if (we_q || err_q) loadData = 32'h0;
  end

  always_comb begin
    state_d        = state_q;
    req_ready_out  = (state_q == IDLE) && rst_in;
    resp_valid_out = (state_q == RESP);
    case (state_q)
      IDLE:    if (req_valid_in) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (resp_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign resp_rdata_out = respData_q;
  assign resp_err_out   = respErr_q;

endmodule
